// File: rtl/control.sv
// Stopwatch run/halt control: two debounced pushbuttons driving a two-state FSM.
// A button acts only on its debounced rising edge, and stop wins over start in the same cycle.
module control #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk5,
  input  logic reset,
  input  logic startPB,
  input  logic stopPB,
  output logic run
);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam int START = 0;
  localparam int STOP  = 1;

  state_t          state;
  logic [1:0]      raw;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      db;
  logic [1:0]      db_q;
  logic [1:0]      press;
  logic [1:0][3:0] cnt;

  assign raw   = {stopPB, startPB};
  assign press = db & ~db_q;

  // Synchronizer -> debounce -> edge history, one lane per button
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // Run/halt FSM; run is registered together with the state
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state <= STOPPED;
      run   <= 1'b0;
    end else begin
      unique case (state)
        STOPPED: begin
          if (press[START] && !press[STOP]) begin
            state <= RUNNING;
            run   <= 1'b1;
          end
        end
        RUNNING: begin
          if (press[STOP]) begin
            state <= STOPPED;
            run   <= 1'b0;
          end
        end
        default: begin
          state <= STOPPED;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Bench for control: per-cycle expected run values are queued with the stimulus
// and popped for comparison one time unit after the following rising edge.
module tb_control;

  logic clk;
  logic reset;
  logic startPB;
  logic stopPB;
  logic run;

  int   errors;
  int   checks;
  logic sbq[$];
  logic exp_run;

  control #(.DEBOUNCE_CYCLES(2)) dut (
    .clk5    (clk),
    .reset   (reset),
    .startPB (startPB),
    .stopPB  (stopPB),
    .run     (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic r, input logic st, input logic sp, input logic e);
    @(negedge clk);
    reset   = r;
    startPB = st;
    stopPB  = sp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL reset_hold cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL reset_release cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_start_hold();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, i >= 4);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL start_hold cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL start_release cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_stop();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, i < 4);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL stop_hold cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL stop_release cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, i < 4, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL stop_in_stopped cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i % 2) == 0, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL bounce cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, i >= 4);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL bounce_then_hold cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL bounce_release cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i < 6, i < 6, i < 4);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL both_in_running cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i < 6, i < 6, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL both_in_stopped cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_hold_other();
    // start held throughout; stop pressed at 6 and released at 14
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, (i >= 6) && (i < 14), (i >= 4) && (i < 10));
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL held_start_no_retrigger cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL held_release cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i < 6, 1'b0, i >= 4);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL repress_start cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (run !== 1'b1) begin errors++; $display("FAIL reset_mid_pre: run=%b required 1", run); end
    reset = 1'b0;
    #1;
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL reset_mid_async: run=%b required 0", run); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL reset_mid_after cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  task automatic test_reset_held_button();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL held_in_reset cyc %0d: run=%b required %b", i, run, exp_run); end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, i >= 4);
      exp_run = sbq.pop_front(); checks++;
      if (run !== exp_run) begin errors++; $display("FAIL held_through_deassert cyc %0d: run=%b required %b", i, run, exp_run); end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    startPB = 1'b0;
    stopPB  = 1'b0;
    test_reset();
    test_start_hold();
    test_stop();
    test_bounce();
    test_simultaneous();
    test_hold_other();
    test_reset_mid();
    test_reset_held_button();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2, range 1..15: consecutive synchronized samples needed to accept a button level change.
REQ-002 clk5  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 startPB  input  1  start pushbutton; raw, asynchronous, may bounce; 1 = pressed.
REQ-005 stopPB  input  1  stop pushbutton; raw, asynchronous, may bounce; 1 = pressed.
REQ-006 run  output  1  registered stopwatch-run enable; 1 = counting, 0 = halted.

Function
REQ-007 Each button SHALL pass through its own two-flop synchronizer (s1, s2) clocked by clk5.
REQ-008 Each button SHALL have a debounced level db, set after s2 has been 1 on DEBOUNCE_CYCLES consecutive edges and cleared after s2 has been 0 on DEBOUNCE_CYCLES consecutive edges; otherwise db holds.
REQ-009 Any s2 value differing from db SHALL restart that button's consecutive-sample count; bounce shorter than DEBOUNCE_CYCLES SHALL NOT change db.
REQ-010 A press event SHALL be the single-cycle 0->1 transition of db; a held button SHALL generate exactly one event.
REQ-011 The FSM SHALL have two states: STOPPED (run=0) and RUNNING (run=1); run SHALL be a direct register of the state.
REQ-012 STOPPED -> RUNNING on a start event with no simultaneous stop event.
REQ-013 RUNNING -> STOPPED on a stop event.
REQ-014 A start event in RUNNING and a stop event in STOPPED SHALL have no effect.
REQ-015 Start and stop events in the same cycle SHALL result in STOPPED (stop has priority).
REQ-016 Latency: button first sampled high at edge E and held SHALL update run at edge E+DEBOUNCE_CYCLES+2 (E+4 at default).
REQ-017 Release of a button SHALL never change run; only press events act.
REQ-018 A button held pressed while the other button is pressed and released SHALL NOT re-trigger until it is released (db cleared) and pressed again.

Reset
REQ-019 While reset=0, run, state, s1, s2, db, edge history and debounce counters SHALL clear to 0 / STOPPED immediately, independent of clk5.
REQ-020 Reset asserted mid-operation SHALL force run=0 at once, regardless of state.
REQ-021 After reset deasserts, first sampling SHALL occur on the next rising clk5 edge; a button held high through deassertion SHALL count as a new press, run rising at E+DEBOUNCE_CYCLES+2.
REQ-022 No output SHALL be X after reset; buttons at 0 during and after reset SHALL leave run=0.

Verification
REQ-023 reset=0 for 5 cycles with buttons idle, then released -> run=0 throughout and after.
REQ-024 startPB held 16 cycles from STOPPED -> run=1 exactly 4 edges after first high sample, stays 1 after release.
REQ-025 stopPB held 8 cycles in RUNNING -> run=0 after 4 edges; second 4-cycle stopPB press while STOPPED -> run stays 0.
REQ-026 startPB toggled 1 cycle high, 1 low, repeated 6 times in STOPPED -> run stays 0 (bounce rejected); then held 5 cycles -> run=1.
REQ-027 startPB and stopPB rising together in STOPPED and in RUNNING -> run=0 in both cases.
REQ-028 reset pulsed to 0 for half a cycle while run=1 -> run=0 immediately, stays 0 with buttons idle.
